// File: rtl/m_dbus_ctrl.sv
// ---------------------------------------------------------------------------
// m_dbus_ctrl
//   Memory-stage data-bus controller for the pipelined MIPS core.
//   It checks M-stage load/store alignment and runs a request/ready handshake
//   with the data bus. While an access is outstanding it stalls the pipeline.
//   It latches the raw read word, the address low bits and the load opcode for
//   the load byte-extender. It also flags AdEL/AdES and bus timeouts.
//
//   State  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no access outstanding; accepts an aligned, unflushed request
//   REQ    | busReq held, waiting for busReady or the timeout count
//   DONE   | access finished; rdValid/excBusTO visible, pipeline advances
//
// Ports
//   clk_i, reset_i        clock, synchronous active-high reset
//   memRead_i/memWrite_i  M-stage load / store (both high = load)
//   memLoadOp_i           000 lw, 001 lh, 010 lb, others lw
//   memStoreOp_i          00 sw, 01 sh, 10 sb, 11 sw
//   addr_i, wData_i       effective address, store data
//   flush_i               M-stage flush
//   busReq_o ... busWData_o  registered bus request
//   busRData_i, busReady_i   bus response
//   stall_o               freeze F/D/E/M pipeline registers
//   lowBit_o, loadOpOut_o, rawData_o, rdValid_o  extender interface
//   excAdEL_o, excAdES_o  misaligned load/store (combinational, IDLE only)
//   excBusTO_o            one-cycle bus timeout pulse
// ---------------------------------------------------------------------------
module m_dbus_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        memRead_i,
    input  logic        memWrite_i,
    input  logic [2:0]  memLoadOp_i,
    input  logic [1:0]  memStoreOp_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wData_i,
    input  logic        flush_i,
    output logic        busReq_o,
    output logic        busWe_o,
    output logic [31:0] busAddr_o,
    output logic [3:0]  busByteEn_o,
    output logic [31:0] busWData_o,
    input  logic [31:0] busRData_i,
    input  logic        busReady_i,
    output logic        stall_o,
    output logic [1:0]  lowBit_o,
    output logic [2:0]  loadOpOut_o,
    output logic [31:0] rawData_o,
    output logic        rdValid_o,
    output logic        excAdEL_o,
    output logic        excAdES_o,
    output logic        excBusTO_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             killed_q,    killed_d;
    logic             busReq_q,    busReq_d;
    logic             busWe_q,     busWe_d;
    logic [31:0]      busAddr_q,   busAddr_d;
    logic [3:0]       busByteEn_q, busByteEn_d;
    logic [31:0]      busWData_q,  busWData_d;
    logic [1:0]       lowBit_q,    lowBit_d;
    logic [2:0]       loadOp_q,    loadOp_d;
    logic [31:0]      rawData_q,   rawData_d;
    logic             rdValid_q,   rdValid_d;
    logic             excBusTO_q,  excBusTO_d;

    logic        is_load;
    logic        is_store;
    logic        ld_misal;
    logic        st_misal;
    logic        in_idle;
    logic        start_ok;
    logic        kill_now;
    logic [3:0]  be_new;
    logic [31:0] wd_new;

    // Request decode; a simultaneous read and write is handled as a load.
    always_comb begin
        is_load  = memRead_i;
        is_store = memWrite_i & ~memRead_i;

        case (memLoadOp_i)
            3'b001:  ld_misal = addr_i[0];
            3'b010:  ld_misal = 1'b0;
            default: ld_misal = |addr_i[1:0];
        endcase

        case (memStoreOp_i)
            2'b01:   st_misal = addr_i[0];
            2'b10:   st_misal = 1'b0;
            default: st_misal = |addr_i[1:0];
        endcase

        in_idle   = (state_q == S_IDLE);
        start_ok  = in_idle & ~flush_i &
                    ((is_load & ~ld_misal) | (is_store & ~st_misal));
        excAdEL_o = in_idle & is_load  & ld_misal & ~flush_i;
        excAdES_o = in_idle & is_store & st_misal & ~flush_i;
        stall_o   = start_ok | (state_q == S_REQ);
    end

    // Byte lanes and replicated store data for the access being launched.
    always_comb begin
        be_new = 4'b1111;
        wd_new = 32'h0;
        if (!is_load) begin
            case (memStoreOp_i)
                2'b01: begin
                    be_new = addr_i[1] ? 4'b1100 : 4'b0011;
                    wd_new = {2{wData_i[15:0]}};
                end
                2'b10: begin
                    be_new = 4'b0001 << addr_i[1:0];
                    wd_new = {4{wData_i[7:0]}};
                end
                default: begin
                    be_new = 4'b1111;
                    wd_new = wData_i;
                end
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        killed_d    = killed_q;
        busReq_d    = busReq_q;
        busWe_d     = busWe_q;
        busAddr_d   = busAddr_q;
        busByteEn_d = busByteEn_q;
        busWData_d  = busWData_q;
        lowBit_d    = lowBit_q;
        loadOp_d    = loadOp_q;
        rawData_d   = rawData_q;
        rdValid_d   = 1'b0;
        excBusTO_d  = 1'b0;
        kill_now    = killed_q | flush_i;

        case (state_q)
            S_IDLE: begin
                killed_d = 1'b0;
                if (start_ok) begin
                    state_d     = S_REQ;
                    cnt_d       = '0;
                    busReq_d    = 1'b1;
                    busWe_d     = is_store;
                    busAddr_d   = {addr_i[31:2], 2'b00};
                    busByteEn_d = be_new;
                    busWData_d  = wd_new;
                    lowBit_d    = addr_i[1:0];
                    loadOp_d    = memLoadOp_i;
                end
            end
            S_REQ: begin
                // A flush does not abort the bus cycle; it only hides the result.
                killed_d = kill_now;
                if (busReady_i) begin
                    // Ready beats a timeout reached in the same cycle.
                    state_d   = S_DONE;
                    busReq_d  = 1'b0;
                    if (!busWe_q) begin
                        rawData_d = busRData_i;
                    end
                    rdValid_d = ~busWe_q & ~kill_now;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = S_DONE;
                    busReq_d   = 1'b0;
                    excBusTO_d = ~kill_now;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                // The pipeline leaves this instruction at the next edge, so no
                // new request is accepted here.
                state_d  = S_IDLE;
                killed_d = 1'b0;
            end
            default: begin
                state_d  = S_IDLE;
                busReq_d = 1'b0;
                killed_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            killed_q    <= 1'b0;
            busReq_q    <= 1'b0;
            busWe_q     <= 1'b0;
            busAddr_q   <= 32'h0;
            busByteEn_q <= 4'h0;
            busWData_q  <= 32'h0;
            lowBit_q    <= 2'b00;
            loadOp_q    <= 3'b000;
            rawData_q   <= 32'h0;
            rdValid_q   <= 1'b0;
            excBusTO_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            killed_q    <= killed_d;
            busReq_q    <= busReq_d;
            busWe_q     <= busWe_d;
            busAddr_q   <= busAddr_d;
            busByteEn_q <= busByteEn_d;
            busWData_q  <= busWData_d;
            lowBit_q    <= lowBit_d;
            loadOp_q    <= loadOp_d;
            rawData_q   <= rawData_d;
            rdValid_q   <= rdValid_d;
            excBusTO_q  <= excBusTO_d;
        end
    end

    assign busReq_o    = busReq_q;
    assign busWe_o     = busWe_q;
    assign busAddr_o   = busAddr_q;
    assign busByteEn_o = busByteEn_q;
    assign busWData_o  = busWData_q;
    assign lowBit_o    = lowBit_q;
    assign loadOpOut_o = loadOp_q;
    assign rawData_o   = rawData_q;
    assign rdValid_o   = rdValid_q;
    assign excBusTO_o  = excBusTO_q;

endmodule
